piece_move_ctrl: RTL
====================

PIECE_MOVE_CTRL -- requirements
Module: piece_move_ctrl

Interface
REQ-001 Parameters SHALL be: ROWS, default 22, grid rows incl. walls; COLS, default 12, grid columns incl. walls; LOCK_DELAY, default 2, gravity ticks a blocked piece waits before locking.
REQ-002 clk  in  1  single system clock, all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  one-cycle pulse that begins a game.
REQ-005 btn_left, btn_right, btn_down  in  1 each  raw level button requests.
REQ-006 drop_tick  in  1  one-cycle gravity pulse.
REQ-007 free_left, free_right, free_below  in  1 each  combinational occupancy lookups of the cells adjacent to (row_out, col_out); 1 = empty.
REQ-008 spawn_free  in  1  spawn cell (row 1, col 5) is empty.
REQ-009 row_out  out  5 and col_out  out  4  next pointer location, feeding the pointer register's row_in/col_in.
REQ-010 newgen  out  1  one-cycle pulse requesting a new piece at spawn.
REQ-011 lock_we  out  1  one-cycle pulse writing the current cell into the occupancy grid.
REQ-012 game_over  out  1  level, held until reset or start.

Function
REQ-013 FSM states SHALL be IDLE, SPAWN, ACTIVE, LOCK_WAIT, LOCK, OVER.
- IDLE -> SPAWN on start.
- SPAWN: 1 cycle; spawn_free=1 -> ACTIVE with newgen=1; spawn_free=0 -> OVER.
- ACTIVE: drop_tick with free_below=0 -> LOCK_WAIT with lock counter cleared.
- LOCK_WAIT: free_below=1 on a later cycle -> ACTIVE; counter reaches LOCK_DELAY -> LOCK.
- LOCK: 1 cycle; lock_we=1, then -> SPAWN.
- OVER -> SPAWN on start (game_over cleared).
REQ-014 Buttons SHALL be registered and rising-edge detected; a held button SHALL produce exactly one move.
REQ-015 At most one move SHALL be accepted per cycle, priority drop_tick > down edge > left edge > right edge; lower-priority requests in the same cycle SHALL be discarded.
REQ-016 Moves are accepted only in ACTIVE or LOCK_WAIT.
- Left: requires free_left=1 and col_out>1.
- Right: requires free_right=1 and col_out<COLS-2.
- Down or drop: requires free_below=1 and row_out<ROWS-2.
- A move whose requirement fails SHALL leave the position unchanged.
REQ-017 An accepted move SHALL update row_out/col_out on the next rising edge (latency 1); rows increase downward.
REQ-018 In LOCK_WAIT each drop_tick with free_below=0 SHALL increment the lock counter; a down edge with free_below=0 SHALL force LOCK immediately.
REQ-019 On newgen, row_out/col_out SHALL load 1/5 in the same edge.
REQ-020 The lock counter SHALL saturate at LOCK_DELAY (width clog2(LOCK_DELAY+1)).
REQ-021 newgen and lock_we SHALL each assert for exactly one cycle and never in the same cycle.

Reset
REQ-022 Reset SHALL force: state=IDLE, row_out=1, col_out=5, newgen=0, lock_we=0, game_over=0, lock counter=0, button history=0.
REQ-023 Reset SHALL take priority over every other input, including mid-LOCK (no lock_we is emitted that cycle).

Structure
REQ-024 A shared package tetris_pkg SHALL hold ROWS, COLS, SPAWN_ROW=1, SPAWN_COL=5 and the FSM state enum; the pointer register SHALL use the same spawn constants.
REQ-025 One sub-module, btn_edge (register plus rising-edge pulse, one instance per button), SHALL be used.

Verification
REQ-026 Reset, start, spawn_free=1 -> newgen pulse one cycle after SPAWN; row_out=1, col_out=5.
REQ-027 Hold btn_left 10 cycles, free_left=1 -> col_out 5->4 only; repeated edges stop at col_out=1.
REQ-028 drop_tick and btn_right edge in the same cycle, both free -> row_out+1, col_out unchanged.
REQ-029 free_below=0, three drop_ticks -> LOCK_WAIT, then lock_we pulse after the 2nd tick in LOCK_WAIT, then newgen.
REQ-030 In LOCK_WAIT, free_below returns to 1 and drop_tick arrives -> back to ACTIVE, row_out+1, no lock_we.
REQ-031 spawn_free=0 at SPAWN -> game_over=1, no newgen; reset asserted during LOCK -> all outputs at their reset values next edge.

Source files
------------

// File: rtl/tetris_pkg.sv
// tetris_pkg: shared grid geometry, spawn location and piece-control FSM states
package tetris_pkg;
  localparam int ROWS = 22;
  localparam int COLS = 12;
  localparam int LOCK_DELAY = 2;
  localparam logic [4:0] SPAWN_ROW = 5'd1;
  localparam logic [3:0] SPAWN_COL = 4'd5;
  typedef enum logic [2:0] {IDLE, SPAWN, ACTIVE, LOCK_WAIT, LOCK, OVER} state_t;
endpackage

// File: rtl/btn_edge.sv
// btn_edge: registers a raw button level and emits a one-cycle pulse on its rising edge
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);
  logic [1:0] hist;
  always_ff @(posedge clk)
    if (reset) hist <= '0;
    else hist <= {hist[0], btn};
  assign pulse = hist[0] & ~hist[1];
endmodule

// File: rtl/piece_move_ctrl.sv
// piece_move_ctrl: falling-piece FSM, move arbitration and pointer register for a grid game
module piece_move_ctrl #(
  parameter int ROWS = tetris_pkg::ROWS,
  parameter int COLS = tetris_pkg::COLS,
  parameter int LOCK_DELAY = tetris_pkg::LOCK_DELAY
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_down,
  input  logic       drop_tick,
  input  logic       free_left,
  input  logic       free_right,
  input  logic       free_below,
  input  logic       spawn_free,
  output logic [4:0] row_out,
  output logic [3:0] col_out,
  output logic       newgen,
  output logic       lock_we,
  output logic       game_over
);
  import tetris_pkg::*;
  localparam int CW = (LOCK_DELAY < 1) ? 1 : $clog2(LOCK_DELAY + 1);
  localparam logic [CW-1:0] LD = CW'(LOCK_DELAY);
  localparam logic [4:0] ROW_MAX = 5'(ROWS - 2);
  localparam logic [3:0] COL_MAX = 4'(COLS - 2);
  state_t state;
  logic [CW-1:0] lock_cnt, cnt_inc;
  logic lf_e, rt_e, dn_e;
  logic mv_en, take_drop, take_down, take_left, take_right;
  logic [4:0] row_nxt;
  logic [3:0] col_nxt;
  btn_edge u_left  (.clk(clk), .reset(reset), .btn(btn_left),  .pulse(lf_e));
  btn_edge u_right (.clk(clk), .reset(reset), .btn(btn_right), .pulse(rt_e));
  btn_edge u_down  (.clk(clk), .reset(reset), .btn(btn_down),  .pulse(dn_e));
  // one winner per cycle: drop > down > left > right, losers are dropped
  always_comb begin
    mv_en = (state == ACTIVE) || (state == LOCK_WAIT);
    take_drop = mv_en && drop_tick;
    take_down = mv_en && !drop_tick && dn_e;
    take_left = mv_en && !drop_tick && !dn_e && lf_e;
    take_right = mv_en && !drop_tick && !dn_e && !lf_e && rt_e;
    row_nxt = ((take_drop || take_down) && free_below && row_out < ROW_MAX) ? row_out + 5'd1 : row_out;
    col_nxt = (take_left && free_left && col_out > 4'd1) ? col_out - 4'd1 :
              (take_right && free_right && col_out < COL_MAX) ? col_out + 4'd1 : col_out;
    cnt_inc = (lock_cnt == LD) ? LD : lock_cnt + CW'(1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      row_out <= SPAWN_ROW;
      col_out <= SPAWN_COL;
      newgen <= 1'b0;
      lock_we <= 1'b0;
      game_over <= 1'b0;
      lock_cnt <= '0;
    end else begin
      newgen <= 1'b0;
      lock_we <= 1'b0;
      row_out <= row_nxt;
      col_out <= col_nxt;
      case (state)
        IDLE: if (start) state <= SPAWN;
        SPAWN:
          if (spawn_free) begin
            state <= ACTIVE;
            newgen <= 1'b1;
            row_out <= SPAWN_ROW;
            col_out <= SPAWN_COL;
          end else begin
            state <= OVER;
            game_over <= 1'b1;
          end
        ACTIVE:
          if (drop_tick && !free_below) begin
            state <= LOCK_WAIT;
            lock_cnt <= '0;
          end
        LOCK_WAIT:
          if (free_below) state <= ACTIVE;
          else if (drop_tick) begin
            lock_cnt <= cnt_inc;
            if (cnt_inc == LD) state <= LOCK;
          end else if (dn_e) state <= LOCK;
        // lock_we fires on leaving LOCK so a reset during LOCK suppresses the write
        LOCK: begin
          lock_we <= 1'b1;
          state <= SPAWN;
        end
        OVER:
          if (start) begin
            state <= SPAWN;
            game_over <= 1'b0;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
